mdr_mem_if: RTL and testbench
=============================

Name: mdr_mem_if

Overview:
- Parametrised memory data register with a built-in memory handshake engine. Successor to the single-cycle MDR.
- Holds the datapath's memory data word and loads it from the bus (MDRin) or from memory via a req/ready handshake with wait states and timeout.
- Supports byte, halfword, word and (64-bit builds) doubleword accesses, with lane alignment, byte enables and optional sign extension.
- Sits between the bus mux and the memory port of the MiniSRC datapath.

Parameters:
- DATA_WIDTH, 32, register and memory data width. Legal values are 32 or 64.
- INIT, 0, value of q after clear. Width is DATA_WIDTH.
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before abort. 0 disables the timeout.
- OFS_W, log2(DATA_WIDTH/8), width of the byte-offset input (derived).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- BusMuxOut  in  DATA_WIDTH  datapath bus value.
- MDRin  in  1  load q from BusMuxOut.
- Read  in  1  start a memory read.
- Write  in  1  start a memory write.
- size  in  2  00 byte, 01 half, 10 word, 11 dword (64-bit builds only; treated as 10 when DATA_WIDTH=32).
- sign_ext  in  1  sign-extend sub-width reads.
- addr_ofs  in  OFS_W  byte offset of the access.
- mem_data_in  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write access.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_data_out  out  DATA_WIDTH  write data, lane-replicated.
- q  out  DATA_WIDTH  MDR contents.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky; set by a timed-out access.
- misalign  out  1  sticky; set by an unaligned access.

Behaviour:
- Reset (clear sampled high at a clock edge, from any state including mid-access):
  - q=INIT; mem_req, mem_we, mem_be, mem_data_out, done, timeout and misalign all 0.
  - State becomes IDLE and the wait counter is 0.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE input priority is Read > Write > MDRin. Only one action is taken per cycle.
- MDRin in IDLE: q <= BusMuxOut at the edge. No memory activity.
- Read in IDLE:
  - Latch size, sign_ext and the aligned offset.
  - Next cycle: mem_req=1, mem_we=0, mem_be=lane mask; state RD_WAIT.
- Write in IDLE:
  - mem_data_out <= low (8<<size) bits of q, replicated across all lanes.
  - mem_be <= lane mask; mem_req=1; mem_we=1; state WR_WAIT.
- Alignment:
  - The effective offset is addr_ofs with its low `size` bits forced to 0.
  - If any of those bits were 1, set misalign (sticky) and still perform the access at the effective offset.
- Lane mask: (2^(2^size))-1, shifted left by the effective offset.
- RD_WAIT:
  - Each cycle with mem_ready=0, the wait counter increments.
  - At the edge where mem_ready=1: q <= the extracted lane, right-justified. Upper bits are zero-filled, or copies of the lane MSB when sign_ext=1. Word/dword at full width is passed unchanged.
  - Then mem_req, mem_we and mem_be go to 0, done=1 for the next cycle, and state returns to IDLE.
- WR_WAIT: same as RD_WAIT, but q is unchanged on completion.
- Latency: best case is Read/Write sampled at edge N, mem_req high after N, mem_ready=1 at edge N+1, done high after N+1 for exactly one cycle.
- Timeout:
  - When TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0: abort the access, leave q unchanged, set timeout, pulse done, return to IDLE.
  - mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- While busy, Read, Write and MDRin are ignored. They are not queued.
- mem_req, mem_we, mem_be and mem_data_out are stable throughout a wait and change only on completion, abort or clear.
- busy = (state != IDLE). done is never asserted while mem_req=1.
- Sticky flags clear only on clear.

Test Plan:
- clear=1 for one edge mid-RD_WAIT, with mem_ready held low → q=INIT, mem_req=0, busy=0, no done pulse.
- MDRin=1, BusMuxOut=0xDEADBEEF → q=0xDEADBEEF one edge later, mem_req stays 0.
- Read, size=00, addr_ofs=3, sign_ext=1, mem_data_in=0x80123456, mem_ready after 3 wait cycles → mem_be=1000, q=0xFFFFFF80, done pulse exactly once; repeat with sign_ext=0 → q=0x00000080.
- q=0x0000ABCD, Write size=01, addr_ofs=2 → mem_we=1, mem_be=1100, mem_data_out=0xABCDABCD, done after mem_ready; q unchanged.
- Read with TIMEOUT=16 and mem_ready never asserted → abort after 16 wait cycles, timeout=1, q unchanged, done pulse; Read/Write/MDRin pulses during the wait are ignored.
- Read size=10, addr_ofs=1 → misalign=1, access at offset 0 with mem_be=1111, misalign stays 1 until clear.

Source files
------------

// File: rtl/mdr_mem_if.sv
// Memory data register with a req/ready memory handshake engine: sub-word
// lane alignment, byte enables, sign extension, wait-state timeout.
module mdr_mem_if #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter int                    TIMEOUT    = 16,
    parameter int                    OFS_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [DATA_WIDTH-1:0]     BusMuxOut,
    input  logic                      MDRin,
    input  logic                      Read,
    input  logic                      Write,
    input  logic [1:0]                size,
    input  logic                      sign_ext,
    input  logic [OFS_W-1:0]          addr_ofs,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [DATA_WIDTH-1:0]     q,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic                      misalign
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         sz_r;
    logic               sx_r;
    logic [OFS_W-1:0]   ofs_r;

    logic [1:0]         sz_eff;
    logic [OFS_W-1:0]   low_mask;
    logic [OFS_W-1:0]   ofs_eff;
    logic               mis;
    logic               start_rd, start_wr, load_bus, finish, abort;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz,
                                                input logic [OFS_W-1:0] ofs);
        logic [NB-1:0] m;
        case (sz)
            2'b00:   m = NB'(1);
            2'b01:   m = NB'(3);
            2'b10:   m = NB'(15);
            default: m = '1;
        endcase
        return m << ofs;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] sz);
        logic [DATA_WIDTH-1:0] r;
        case (sz)
            2'b00:   r = {NB{d[7:0]}};
            2'b01:   r = {(NB/2){d[15:0]}};
            2'b10:   r = {(NB/4){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0] sz,
                                                      input logic [OFS_W-1:0] ofs,
                                                      input logic sx);
        logic [DATA_WIDTH-1:0] s;
        logic signed [7:0]     b;
        logic signed [15:0]    h;
        logic signed [31:0]    w;
        logic [DATA_WIDTH-1:0] r;
        s = d >> {ofs, 3'b000};
        b = s[7:0];
        h = s[15:0];
        w = s[31:0];
        case (sz)
            2'b00:   r = sx ? DATA_WIDTH'(b) : DATA_WIDTH'(s[7:0]);
            2'b01:   r = sx ? DATA_WIDTH'(h) : DATA_WIDTH'(s[15:0]);
            2'b10:   r = sx ? DATA_WIDTH'(w) : DATA_WIDTH'(s[31:0]);
            default: r = s;
        endcase
        return r;
    endfunction

    // Doubleword only exists in 64-bit builds; narrower builds fold it to word.
    assign sz_eff   = (DATA_WIDTH == 32 && size == 2'b11) ? 2'b10 : size;
    assign low_mask = OFS_W'((1 << sz_eff) - 1);
    assign ofs_eff  = addr_ofs & ~low_mask;
    assign mis      = |(addr_ofs & low_mask);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        start_rd  = 1'b0;
        start_wr  = 1'b0;
        load_bus  = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (Read) begin
                    start_rd  = 1'b1;
                    state_nxt = RD_WAIT;
                end else if (Write) begin
                    start_wr  = 1'b1;
                    state_nxt = WR_WAIT;
                end else if (MDRin) begin
                    load_bus  = 1'b1;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // A ready arriving on the timeout cycle still wins.
                if (mem_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT > 0 && cnt == TMO) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q            <= INIT;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_data_out <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            misalign     <= 1'b0;
            cnt          <= '0;
            sz_r         <= '0;
            sx_r         <= 1'b0;
            ofs_r        <= '0;
        end else begin
            done <= finish | abort;
            if (load_bus)
                q <= BusMuxOut;
            if (start_rd || start_wr) begin
                sz_r    <= sz_eff;
                sx_r    <= sign_ext;
                ofs_r   <= ofs_eff;
                mem_req <= 1'b1;
                mem_we  <= start_wr;
                mem_be  <= lane_mask(sz_eff, ofs_eff);
                cnt     <= '0;
                if (mis)
                    misalign <= 1'b1;
                if (start_wr)
                    mem_data_out <= replicate(q, sz_eff);
            end
            if (busy && !mem_ready)
                cnt <= cnt + CNT_W'(1);
            if (finish || abort) begin
                mem_req      <= 1'b0;
                mem_we       <= 1'b0;
                mem_be       <= '0;
                mem_data_out <= '0;
                cnt          <= '0;
            end
            if (abort)
                timeout <= 1'b1;
            if (finish && state == RD_WAIT)
                q <= extract(mem_data_in, sz_r, ofs_r, sx_r);
        end
    end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if (32-bit, INIT=0, TIMEOUT=16): vector table of
// single accesses plus hand sequences for timeout, clear and sticky flags.
module tb_mdr_mem_if;

    logic        clock = 1'b0;
    logic        clear, MDRin, Read, Write, sign_ext, mem_ready;
    logic [31:0] BusMuxOut, mem_data_in;
    logic [1:0]  size, addr_ofs;
    logic        mem_req, mem_we, busy, done, timeout, misalign;
    logic [3:0]  mem_be;
    logic [31:0] mem_data_out, q;

    int n_cmp  = 0;
    int n_fail = 0;

    mdr_mem_if #(.DATA_WIDTH(32), .INIT(32'h0), .TIMEOUT(16)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
        .Read(Read), .Write(Write), .size(size), .sign_ext(sign_ext),
        .addr_ofs(addr_ofs), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_data_out(mem_data_out), .q(q), .busy(busy), .done(done),
        .timeout(timeout), .misalign(misalign)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] qpre;
        logic        rd;
        logic [1:0]  sz;
        logic        sx;
        logic [1:0]  ofs;
        logic [31:0] mdata;
        int          waits;
        logic [31:0] exp_q;
        logic [3:0]  exp_be;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load_q(input logic [31:0] v);
        BusMuxOut = v;
        MDRin     = 1'b1;
        tick();
        MDRin     = 1'b0;
    endtask

    task automatic start(input logic rd, input logic [1:0] sz, input logic sx,
                         input logic [1:0] ofs);
        Read     = rd;
        Write    = ~rd;
        size     = sz;
        sign_ext = sx;
        addr_ofs = ofs;
        tick();
        Read     = 1'b0;
        Write    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        do_clear();
        load_q(v.qpre);
        check({tag, "_mdrin_q"}, q, v.qpre);
        check({tag, "_mdrin_req"}, {31'b0, mem_req}, 32'd0);
        mem_data_in = v.mdata;
        start(v.rd, v.sz, v.sx, v.ofs);
        check({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        check({tag, "_we"}, {31'b0, mem_we}, {31'b0, ~v.rd});
        check({tag, "_be"}, {28'b0, mem_be}, {28'b0, v.exp_be});
        if (!v.rd) check({tag, "_dout"}, mem_data_out, v.exp_dout);
        check({tag, "_mis"}, {31'b0, misalign}, {31'b0, v.exp_mis});
        for (int i = 0; i < v.waits; i++) begin
            tick();
            check({tag, "_wait_state"}, {done, mem_req, busy, mem_be}, {3'b011, v.exp_be});
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_idle"}, {29'b0, mem_req, busy, mem_we}, 32'd0);
        check({tag, "_q"}, q, v.exp_q);
        tick();
        check({tag, "_done_one"}, {31'b0, done}, 32'd0);
        check({tag, "_mis_hold"}, {31'b0, misalign}, {31'b0, v.exp_mis});
    endtask

    initial begin
        int n;
        clear = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; sign_ext = 1'b0;
        mem_ready = 1'b0; BusMuxOut = '0; mem_data_in = '0; size = '0; addr_ofs = '0;

        //          qpre          rd  sz     sx  ofs    mdata         w  exp_q         be       dout          mis
        vecs[0]  = '{32'h5A5A5A5A, 1, 2'b00, 1, 2'd3, 32'h80123456, 3, 32'hFFFFFF80, 4'b1000, 32'h0,        0};
        vecs[1]  = '{32'h5A5A5A5A, 1, 2'b00, 0, 2'd3, 32'h80123456, 3, 32'h00000080, 4'b1000, 32'h0,        0};
        vecs[2]  = '{32'h5A5A5A5A, 1, 2'b01, 1, 2'd2, 32'h80011234, 0, 32'hFFFF8001, 4'b1100, 32'h0,        0};
        vecs[3]  = '{32'h5A5A5A5A, 1, 2'b01, 1, 2'd0, 32'h80011234, 1, 32'h00001234, 4'b0011, 32'h0,        0};
        vecs[4]  = '{32'h5A5A5A5A, 1, 2'b10, 1, 2'd0, 32'hCAFEBABE, 2, 32'hCAFEBABE, 4'b1111, 32'h0,        0};
        vecs[5]  = '{32'h5A5A5A5A, 1, 2'b00, 0, 2'd1, 32'h0000A500, 0, 32'h000000A5, 4'b0010, 32'h0,        0};
        vecs[6]  = '{32'h0000ABCD, 0, 2'b01, 0, 2'd2, 32'h0,        2, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 0};
        vecs[7]  = '{32'h12345678, 0, 2'b00, 0, 2'd0, 32'h0,        1, 32'h12345678, 4'b0001, 32'h78787878, 0};
        vecs[8]  = '{32'hDEADBEEF, 0, 2'b10, 0, 2'd0, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0};
        vecs[9]  = '{32'h5A5A5A5A, 1, 2'b11, 0, 2'd0, 32'h01020304, 1, 32'h01020304, 4'b1111, 32'h0,        0};
        vecs[10] = '{32'h5A5A5A5A, 1, 2'b10, 0, 2'd1, 32'h11223344, 2, 32'h11223344, 4'b1111, 32'h0,        1};
        vecs[11] = '{32'h5A5A5A5A, 1, 2'b01, 0, 2'd3, 32'hFEDC0000, 0, 32'h0000FEDC, 4'b1100, 32'h0,        1};

        do_clear();
        check("rst_q", q, 32'h0);
        check("rst_ctl", {25'b0, mem_req, mem_we, busy, done, timeout, misalign, 1'b0}, 32'd0);
        check("rst_be_dout", {28'b0, mem_be} | mem_data_out, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Timeout: no ready; stray requests during the wait must be dropped.
        do_clear();
        load_q(32'h13579BDF);
        start(1'b1, 2'b10, 1'b0, 2'd0);
        check("tmo_req", {31'b0, mem_req}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (n == 2) begin MDRin = 1'b1; BusMuxOut = 32'hFFFF0000; end
            if (n == 3) begin MDRin = 1'b0; Read = 1'b1; Write = 1'b1; end
            if (n == 4) begin Read = 1'b0; Write = 1'b0; end
            if (n < 16) check("tmo_req_held", {31'b0, mem_req}, 32'd1);
            tick();
            n++;
        end
        check("tmo_cycles", n, 17);
        check("tmo_flag", {31'b0, timeout}, 32'd1);
        check("tmo_q", q, 32'h13579BDF);
        check("tmo_req_low", {30'b0, mem_req, busy}, 32'd0);
        tick();
        check("tmo_not_queued", {29'b0, mem_req, busy, done}, 32'd0);
        mem_data_in = 32'h00000042;
        start(1'b1, 2'b00, 1'b0, 2'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("tmo_sticky_q", q, 32'h00000042);
        check("tmo_sticky", {31'b0, timeout}, 32'd1);

        // Ready on the cycle the counter reaches the limit is a success.
        do_clear();
        load_q(32'h0BADF00D);
        mem_data_in = 32'h76543210;
        start(1'b1, 2'b10, 1'b0, 2'd0);
        for (int i = 0; i < 16; i++) tick();
        check("edge_still_req", {31'b0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("edge_done", {31'b0, done}, 32'd1);
        check("edge_no_tmo", {31'b0, timeout}, 32'd0);
        check("edge_q", q, 32'h76543210);

        // Clear during RD_WAIT.
        do_clear();
        load_q(32'h89ABCDEF);
        start(1'b1, 2'b10, 1'b0, 2'd1);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_q", q, 32'h0);
        check("clr_ctl", {27'b0, mem_req, busy, done, misalign, timeout}, 32'd0);
        tick();
        check("clr_no_done", {30'b0, done, busy}, 32'd0);

        // Misalign stays set across a later aligned access until clear.
        start(1'b1, 2'b01, 1'b0, 2'd1);
        mem_ready = 1'b1;
        tick();
        start(1'b1, 2'b00, 1'b0, 2'd0);
        tick();
        mem_ready = 1'b0;
        check("mis_sticky", {31'b0, misalign}, 32'd1);
        do_clear();
        check("mis_cleared", {31'b0, misalign}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
